hi_lo_mdu_controller: RTL and testbench
=======================================

Name: hi_lo_mdu_controller

Overview:
Multi-cycle multiply/divide sequencer owning the MIPS HI/LO registers, sitting beside the single-cycle ALU in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands.
- Runs a fixed-latency multiply or a 32-iteration restoring divide.
- Commits results to HI/LO and requests pipeline stalls while busy.

Parameters:
MUL_LATENCY, 3, cycles from multiply accept to HI/LO commit; legal range 1..8.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  command valid from execute stage
op  input  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 7 treated as NONE
operand1  input  32  rs value (multiplicand/dividend/MTHI-MTLO source)
operand2  input  32  rt value (multiplier/divisor)
readHiLo  input  1  MFHI/MFLO in execute stage this cycle
flush  input  1  abort in-flight operation (exception/branch squash)
busy  output  1  operation in flight (state != IDLE)
stall  output  1  busy && ((start && op != NONE) || readHiLo)
done  output  1  one-cycle pulse, the cycle the new HI/LO is first visible
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-divide): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal operand latches=0.
- States: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- Accept rule: a command is accepted only on a clock edge where state=IDLE, start=1, flush=0 and op is not NONE. When start=1 and busy=1 the command is ignored; stall=1 holds the pipeline so it re-presents the command.
- MTHI/MTLO: accepted in IDLE. hi or lo = operand1 at that edge. No busy, done=0.
- MULT/MULTU:
  - Operands latched at accept; go to MUL_WAIT with counter=MUL_LATENCY-1.
  - Decrement each cycle. Leave MUL_WAIT on the edge where counter=0, writing {hi,lo}=64-bit product (signed for MULT, unsigned for MULTU).
  - busy is high for exactly MUL_LATENCY cycles after accept. done pulses in the following cycle.
- DIV/DIVU:
  - Latch |dividend| and |divisor| (magnitudes for DIV; raw for DIVU), plus the quotient sign (a31^b31) and remainder sign (a31) for DIV.
  - DIV_ITER: 32 cycles, one restoring quotient bit per cycle, MSB first.
  - DIV_FIX: 1 cycle; negate quotient/remainder as required, then write lo=quotient, hi=remainder.
  - busy high for 33 cycles after accept. done pulses in the following cycle.
- Divide by zero has deterministic results:
  - Unsigned: lo=0xFFFFFFFF, hi=dividend.
  - Signed: lo=0x00000001 if dividend<0, else 0xFFFFFFFF; hi=dividend.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Flush: any state returns to IDLE next edge. HI/LO keep pre-operation values, done=0. Flush in IDLE together with start means the command is not accepted.
- Flush on the commit edge (last MUL_WAIT or DIV_FIX cycle): flush wins, no commit.
- readHiLo while busy: stall=1 until the done cycle. hi/lo hold the committed value in the done cycle, so the read proceeds then.
- hi/lo change only on MTHI/MTLO accept, multiply/divide commit, or reset.

Optional Feature:
MDU_DIV_ZERO_FAST_EN:
- Defined: DIV/DIVU with operand2=0 skips DIV_ITER and goes directly to DIV_FIX, committing the same HI/LO values listed above. busy lasts 1 cycle.
- Undefined: divide by zero runs the full 33-cycle sequence.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003, MUL_LATENCY=3 -> busy high 3 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV −7 (0xFFFFFFF9) / 2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- Divide by zero: DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Run in both macro builds; check 33-cycle vs 1-cycle busy.
- MTHI 0xAAAA0000 then MTLO 0x5555, then DIVU started; assert flush at cycle 10 -> busy=0 next cycle, done never pulses, hi=0xAAAA0000, lo=0x5555.
- Start MULTU while DIV busy, with readHiLo=1 -> stall=1 throughout; MULTU ignored until IDLE, then accepted on re-presentation; stall drops in the done cycle.
- Assert reset at cycle 20 of DIV -> outputs immediately hi=lo=0, busy=0, done=0; next command accepted normally.

Source files
------------

// File: rtl/hi_lo_mdu_controller.sv
// hi_lo_mdu_controller: multi-cycle multiply/divide sequencer that owns the MIPS HI/LO registers.
// Multiplies commit after MUL_LATENCY cycles. Divides run a 32-iteration restoring loop and then
// one sign-fixup cycle.
// Optional macro MDU_DIV_ZERO_FAST_EN: a divide by zero skips the iteration loop. The results are
// identical; only the latency is shorter.
module hi_lo_mdu_controller #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        readHiLo,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_ITER,
        DIV_FIX
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [31:0] rem_q;
    logic        signed_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    logic        cmd_valid;
    logic        accept;
    logic        commit_mul;
    logic        commit_div;
    logic        is_div_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    // Command decode. Op codes 0 and 7 are NONE.
    assign cmd_valid     = start && (op >= OP_MULT) && (op <= OP_MTLO);
    assign accept        = (state_q == IDLE) && cmd_valid && !flush;
    assign busy          = (state_q != IDLE);
    assign stall         = busy && (cmd_valid || readHiLo);

    // DIV works on magnitudes. Negating 0x80000000 leaves it unchanged, which is the correct
    // unsigned magnitude.
    assign is_div_signed = (op == OP_DIV);
    assign mag_a         = (is_div_signed && operand1[31]) ? (~operand1 + 32'd1) : operand1;
    assign mag_b         = (is_div_signed && operand2[31]) ? (~operand2 + 32'd1) : operand2;

    // Sign-extending both operands to 64 bits gives the correct two's-complement signed product
    // in the low 64 bits.
    assign product = {{32{signed_q & opa_q[31]}}, opa_q} * {{32{signed_q & opb_q[31]}}, opb_q};

    // One restoring step. The next dividend bit is shifted into the partial remainder.
    // The remainder stays below the divisor, so the difference always fits in 32 bits.
    assign shifted = {rem_q, opa_q[31]};
    assign fits    = (shifted >= {1'b0, opb_q});
    assign diff    = shifted[31:0] - opb_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and commit decisions. Flush overrides everything, including the commit edge.
    always_comb begin
        state_d    = state_q;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU) begin
                        state_d = MUL_WAIT;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
`ifdef MDU_DIV_ZERO_FAST_EN
                        state_d = (operand2 == 32'd0) ? DIV_FIX : DIV_ITER;
`else
                        state_d = DIV_ITER;
`endif
                    end
                end
            end
            MUL_WAIT: begin
                if (count_q == 5'd0) begin
                    state_d    = IDLE;
                    commit_mul = 1'b1;
                end
            end
            DIV_ITER: begin
                if (count_q == 5'd0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d    = IDLE;
                commit_div = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            commit_mul = 1'b0;
            commit_div = 1'b0;
        end
    end

    // Datapath: operand latches, iteration counter, divide steps, and HI/LO commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= 5'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            rem_q     <= 32'd0;
            signed_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            done      <= 1'b0;
        end else begin
            done <= commit_mul || commit_div;
            if (accept) begin
                case (op)
                    OP_MTHI: hi <= operand1;
                    OP_MTLO: lo <= operand1;
                    OP_MULT, OP_MULTU: begin
                        opa_q    <= operand1;
                        opb_q    <= operand2;
                        signed_q <= (op == OP_MULT);
                        count_q  <= 5'(MUL_LATENCY - 1);
                    end
                    OP_DIV, OP_DIVU: begin
                        opa_q     <= mag_a;
                        opb_q     <= mag_b;
                        rem_q     <= 32'd0;
                        quo_neg_q <= is_div_signed && (operand1[31] ^ operand2[31]);
                        rem_neg_q <= is_div_signed && operand1[31];
                        count_q   <= 5'd31;
`ifdef MDU_DIV_ZERO_FAST_EN
                        // Preload what the full loop would produce for a zero divisor.
                        if (operand2 == 32'd0) begin
                            opa_q <= 32'hFFFF_FFFF;
                            rem_q <= mag_a;
                        end
`endif
                    end
                    default: ;
                endcase
            end else if (state_q == MUL_WAIT) begin
                if (count_q != 5'd0) begin
                    count_q <= count_q - 5'd1;
                end
            end else if (state_q == DIV_ITER) begin
                rem_q <= fits ? diff : shifted[31:0];
                opa_q <= {opa_q[30:0], fits};
                if (count_q != 5'd0) begin
                    count_q <= count_q - 5'd1;
                end
            end
            if (commit_mul) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
            if (commit_div) begin
                lo <= quo_neg_q ? (~opa_q + 32'd1) : opa_q;
                hi <= rem_neg_q ? (~rem_q + 32'd1) : rem_q;
            end
        end
    end

endmodule

// File: tb/tb_hi_lo_mdu_controller.sv
// Self-checking bench for hi_lo_mdu_controller.
// It runs directed cases and randomized commands. Expected values come from an arithmetic
// reference model.
module tb_hi_lo_mdu_controller;

    localparam int MUL_LAT = 3;
`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        readHiLo;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    hi_lo_mdu_controller #(.MUL_LATENCY(MUL_LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .readHiLo(readHiLo), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: new HI/LO values and busy length, computed from the arithmetic rules.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int lat);
        int sa, sb;
        longint p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        lat = 0;
        case (o)
            3'd1: begin p = longint'(sa) * longint'(sb); {h, l} = p; lat = MUL_LAT; end
            3'd2: begin pu = 64'(a) * 64'(b); {h, l} = pu; lat = MUL_LAT; end
            3'd3: begin
                if (b == 0) begin
                    l = (sa < 0) ? 32'h1 : 32'hFFFF_FFFF; h = a; lat = DIV0_LAT;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'h0; lat = 33;
                end else begin
                    l = sa / sb; h = sa % sb; lat = 33;
                end
            end
            3'd4: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; lat = DIV0_LAT; end
                else begin l = a / b; h = a % b; lat = 33; end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    // Count busy cycles from the cycle after accept, then check the done cycle and results.
    task automatic waitAndCheck(input string tag, input int lat);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        checkOutput({tag, " busy_cycles"}, 64'(n), 64'(lat));
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'(exp_hi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(exp_lo));
        tick();
        checkOutput({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    // Present one command, then check it against the model.
    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        int lat;
        model(o, a, b, exp_hi, exp_lo, lat);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        tick();
        start = 1'b0; op = 3'd0;
        if (lat == 0) begin
            checkOutput({tag, " busy"}, 64'(busy), 64'd0);
            checkOutput({tag, " done"}, 64'(done), 64'd0);
            checkOutput({tag, " hi"}, 64'(hi), 64'(exp_hi));
            checkOutput({tag, " lo"}, 64'(lo), 64'(exp_lo));
        end else begin
            waitAndCheck(tag, lat);
        end
    endtask

    initial begin
        int lat;
        logic saw_done;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'd0; operand1 = 32'd0; operand2 = 32'd0;
        readHiLo = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset stall", 64'(stall), 64'd0);
        reset = 1'b0;
        tick();

        // Directed arithmetic cases
        applyStimulus("mult", 3'd1, 32'hFFFF_FFFE, 32'h3);
        checkOutput("mult plan_hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult plan_lo", 64'(lo), 64'hFFFF_FFFA);
        applyStimulus("multu", 3'd2, 32'hFFFF_FFFE, 32'h3);
        checkOutput("multu plan_hi", 64'(hi), 64'h2);
        applyStimulus("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'h2);
        checkOutput("div plan_lo", 64'(lo), 64'hFFFF_FFFD);
        applyStimulus("divu_100_7", 3'd4, 32'd100, 32'd7);
        applyStimulus("divu_by0", 3'd4, 32'h1234_5678, 32'h0);
        applyStimulus("div_by0_neg", 3'd3, 32'hFFFF_FFFB, 32'h0);
        applyStimulus("div_by0_pos", 3'd3, 32'h0000_0005, 32'h0);
        applyStimulus("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("op7_none", 3'd7, 32'hDEAD_BEEF, 32'h1);

        // Flush mid-divide: HI/LO keep their MTHI/MTLO values and done never pulses
        applyStimulus("mthi", 3'd5, 32'hAAAA_0000, 32'h0);
        applyStimulus("mtlo", 3'd6, 32'h0000_5555, 32'h0);
        start = 1'b1; op = 3'd4; operand1 = 32'd1000; operand2 = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush busy", 64'(busy), 64'd0);
        saw_done = done;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_done |= done;
        end
        checkOutput("flush no_done", 64'(saw_done), 64'd0);
        checkOutput("flush hi", 64'(hi), 64'hAAAA_0000);
        checkOutput("flush lo", 64'(lo), 64'h0000_5555);

        // Flush on the multiply commit edge: no commit
        start = 1'b1; op = 3'd2; operand1 = 32'h7; operand2 = 32'h9;
        tick();
        start = 1'b0;
        repeat (MUL_LAT - 1) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_commit busy", 64'(busy), 64'd0);
        checkOutput("flush_commit done", 64'(done), 64'd0);
        checkOutput("flush_commit lo", 64'(lo), 64'h0000_5555);

        // Flush together with start in IDLE blocks the accept
        start = 1'b1; op = 3'd5; operand1 = 32'h1111_1111; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_idle hi", 64'(hi), 64'hAAAA_0000);

        // MULTU re-presented while a DIV is busy, with readHiLo high
        model(3'd3, 32'd1000, 32'd7, exp_hi, exp_lo, lat);
        start = 1'b1; op = 3'd3; operand1 = 32'd1000; operand2 = 32'd7;
        tick();
        op = 3'd2; operand1 = 32'hFFFF_FFFE; operand2 = 32'h3; readHiLo = 1'b1;
        saw_done = 1'b1;
        for (int i = 0; i < 100 && busy; i++) begin
            saw_done &= stall;
            tick();
        end
        checkOutput("stall held", 64'(saw_done), 64'd1);
        checkOutput("stall drop", 64'(stall), 64'd0);
        checkOutput("stall done", 64'(done), 64'd1);
        checkOutput("stall div_hi", 64'(hi), 64'(exp_hi));
        checkOutput("stall div_lo", 64'(lo), 64'(exp_lo));
        model(3'd2, 32'hFFFF_FFFE, 32'h3, exp_hi, exp_lo, lat);
        tick();
        start = 1'b0; op = 3'd0; readHiLo = 1'b0;
        waitAndCheck("multu_after_stall", lat);

        // Asynchronous reset at cycle 20 of a divide
        start = 1'b1; op = 3'd3; operand1 = 32'hFFFF_0000; operand2 = 32'd13;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("areset hi", 64'(hi), 64'd0);
        checkOutput("areset lo", 64'(lo), 64'd0);
        checkOutput("areset busy", 64'(busy), 64'd0);
        checkOutput("areset done", 64'(done), 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        applyStimulus("after_reset", 3'd4, 32'd100, 32'd7);

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
